// File: rtl/mod3_pkg.sv
// Shared types and constants for the mod-3 check scheduler and its serial core.
package mod3_pkg;

    // Sequencer states: wait for a request, shift the operand, present the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Remainder of the operand seen so far; encoding 3 never occurs.
    typedef logic [1:0] rem_t;

    localparam rem_t REM0 = 2'd0;
    localparam rem_t REM1 = 2'd1;
    localparam rem_t REM2 = 2'd2;

    // Requester index (two requesters).
    typedef logic id_t;

    // One MSB-first step: appending bit b to a value with remainder r
    // gives remainder (2*r + b) mod 3.
    function automatic rem_t rem_step(input rem_t r, input logic b);
        rem_t n;
        case ({r, b})
            3'b00_0: n = REM0;
            3'b00_1: n = REM1;
            3'b01_0: n = REM2;
            3'b01_1: n = REM0;
            3'b10_0: n = REM1;
            3'b10_1: n = REM2;
            default: n = REM0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod3_check_sched_if.sv
// Request/result bundle between the requesters and the mod-3 scheduler.
interface mod3_check_sched_if #(
    parameter int W = 8
);
    import mod3_pkg::*;

    logic [1:0]   req_valid;
    logic [W-1:0] req_data0;
    logic [W-1:0] req_data1;
    logic [1:0]   req_ready;
    logic         res_valid;
    logic         res_ready;
    id_t          res_id;
    rem_t         res_rem;
    logic         res_div3;
    logic         busy;

    // Requester / result-consumer side.
    modport master (
        output req_valid, req_data0, req_data1, res_ready,
        input  req_ready, res_valid, res_id, res_rem, res_div3, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_data0, req_data1, res_ready,
        output req_ready, res_valid, res_id, res_rem, res_div3, busy
    );

endinterface

// File: rtl/mod3_serial_core.sv
// Three-state remainder FSM: folds one operand bit per enabled cycle, MSB first.
module mod3_serial_core
    import mod3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output rem_t rem
);

    rem_t rem_reg;
    rem_t rem_next;

    // Next remainder from the current one and the incoming bit.
    always_comb begin
        rem_next = rem_step(rem_reg, bit_in);
    end

    // Remainder register; clear wins over enable so a new job always starts at 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rem_reg <= REM0;
        end else if (en) begin
            rem_reg <= rem_next;
        end
    end

    assign rem = rem_reg;

endmodule

// File: rtl/mod3_check_sched.sv
// Round-robin scheduler sharing one serial mod-3 core between two requesters.
module mod3_check_sched
    import mod3_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mod3_check_sched_if.slave bus
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t           state_reg;
    state_t           state_next;
    logic [W-1:0]     shift_reg;
    logic [CNT_W-1:0] cnt_reg;
    id_t              ptr_reg;       // requester that wins when both are valid
    id_t              res_id_reg;
    logic             res_valid_reg;
    logic             busy_reg;

    id_t              grant_id;
    logic             grant_en;
    logic [1:0]       req_ready_w;
    logic             req_hs;
    logic             res_hs;
    logic             last_shift;
    logic             core_clr;
    logic             core_en;
    rem_t             core_rem;

    // Arbitration winner: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        case (bus.req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            default: grant_id = ptr_reg;
        endcase
    end

    // Per-requester ready: only the winner, only in IDLE, never during reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready_w[gi] = grant_en && bus.req_valid[gi] && (grant_id == id_t'(gi));
        end
    endgenerate

    assign req_hs     = |(bus.req_valid & req_ready_w);
    assign res_hs     = res_valid_reg && bus.res_ready;
    assign last_shift = (cnt_reg == CNT_W'(W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_hs)     state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (res_hs)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: grant enable and core controls.
    always_comb begin
        grant_en = 1'b0;
        core_clr = 1'b0;
        core_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                grant_en = !rst;
                core_clr = req_hs;
            end
            SHIFT:   core_en = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, shifting, counting, result flags and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg     <= '0;
            cnt_reg       <= '0;
            ptr_reg       <= 1'b0;
            res_id_reg    <= 1'b0;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            busy_reg <= (state_next != IDLE);
            case (state_reg)
                IDLE: begin
                    if (req_hs) begin
                        shift_reg  <= grant_id ? bus.req_data1 : bus.req_data0;
                        res_id_reg <= grant_id;
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_shift) begin
                        res_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_hs) begin
                        res_valid_reg <= 1'b0;
                        ptr_reg       <= ~res_id_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    mod3_serial_core u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (core_clr),
        .en     (core_en),
        .bit_in (shift_reg[W-1]),
        .rem    (core_rem)
    );

    // The core holds its remainder while in DONE, so the result fields stay stable.
    assign bus.req_ready = req_ready_w;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_id    = res_id_reg;
    assign bus.res_rem   = core_rem;
    assign bus.res_div3  = res_valid_reg && (core_rem == REM0);
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_mod3_check_sched.sv
// Directed plus randomized bench for the mod-3 scheduler (W=8 and W=1 builds).
module tb_mod3_check_sched;

    localparam int W8 = 8;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic last_served;   // model: requester served most recently (1 => 0 favoured)

    mod3_check_sched_if #(.W(W8)) bus8 ();
    mod3_check_sched_if #(.W(1))  bus1 ();

    mod3_check_sched #(.W(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    mod3_check_sched #(.W(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus8.req_valid = 2'b00;
        bus8.res_ready = 1'b0;
        bus1.req_valid = 2'b00;
        bus1.res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        last_served = 1'b1;
        #1;
    endtask

    // One complete job on the W=8 instance, checked against mod-3 arithmetic
    // and the round-robin rule (tie goes to whoever was not served last).
    task automatic run8(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input int stall, input bit keep_valid);
        int   win;
        int   exp_rem;
        logic [7:0] wd;
        if (v == 2'b01)      win = 0;
        else if (v == 2'b10) win = 1;
        else                 win = (last_served == 1'b0) ? 1 : 0;
        wd = (win == 1) ? d1 : d0;
        exp_rem = int'(wd) % 3;
        bus8.req_valid = v;
        bus8.req_data0 = d0;
        bus8.req_data1 = d1;
        bus8.res_ready = 1'b0;
        #1;
        check("idle_busy", bus8.busy, 0);
        check("grant", bus8.req_ready, 32'(1 << win));
        step();
        bus8.req_valid = keep_valid ? v : 2'b00;
        #1;
        check("shift_busy", bus8.busy, 1);
        check("shift_ready", bus8.req_ready, 0);
        repeat (W8 - 1) step();
        check("early_valid", bus8.res_valid, 0);
        step();
        check("res_valid", bus8.res_valid, 1);
        check("res_id", bus8.res_id, win);
        check("res_rem", bus8.res_rem, exp_rem);
        check("res_div3", bus8.res_div3, (exp_rem == 0) ? 1 : 0);
        for (int s = 0; s < stall; s++) begin
            step();
            check("hold_valid", bus8.res_valid, 1);
            check("hold_id", bus8.res_id, win);
            check("hold_rem", bus8.res_rem, exp_rem);
            check("hold_div3", bus8.res_div3, (exp_rem == 0) ? 1 : 0);
            check("hold_ready", bus8.req_ready, 0);
        end
        bus8.res_ready = 1'b1;
        step();
        bus8.res_ready = 1'b0;
        check("post_valid", bus8.res_valid, 0);
        check("post_busy", bus8.busy, 0);
        last_served = 1'(win);
        $display("job W=8 id=%0d data=%0d stall=%0d rem=%0d", win, wd, stall, exp_rem);
    endtask

    // One job on the W=1 instance from requester 0.
    task automatic run1(input logic d);
        bus1.req_valid = 2'b01;
        bus1.req_data0 = d;
        bus1.req_data1 = 1'b0;
        bus1.res_ready = 1'b0;
        #1;
        check("w1_grant", bus1.req_ready, 1);
        step();
        bus1.req_valid = 2'b00;
        check("w1_busy", bus1.busy, 1);
        check("w1_early", bus1.res_valid, 0);
        step();
        check("w1_valid", bus1.res_valid, 1);
        check("w1_rem", bus1.res_rem, 32'(d));
        check("w1_div3", bus1.res_div3, (d == 1'b0) ? 1 : 0);
        bus1.res_ready = 1'b1;
        step();
        bus1.res_ready = 1'b0;
        check("w1_post", bus1.res_valid, 0);
        $display("job W=1 data=%0d rem=%0d", d, d);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        bus8.req_data0 = '0;
        bus8.req_data1 = '0;
        bus1.req_data0 = '0;
        bus1.req_data1 = '0;
        do_reset();

        // Reset state.
        check("rst_valid", bus8.res_valid, 0);
        check("rst_busy", bus8.busy, 0);
        check("rst_id", bus8.res_id, 0);
        check("rst_rem", bus8.res_rem, 0);
        check("rst_div3", bus8.res_div3, 0);

        // Single requesters.
        run8(2'b01, 8'd27, 8'd0, 0, 1'b0);
        run8(2'b10, 8'd0, 8'd200, 0, 1'b0);

        // Both held asserted: 0, then 1, then 0.
        do_reset();
        run8(2'b11, 8'd9, 8'd10, 0, 1'b1);
        run8(2'b11, 8'd9, 8'd10, 0, 1'b1);
        run8(2'b11, 8'd9, 8'd10, 0, 1'b0);

        // Backpressure in DONE.
        run8(2'b01, 8'd100, 8'd0, 5, 1'b0);

        // Reset during the 4th SHIFT cycle.
        bus8.req_valid = 2'b01;
        bus8.req_data0 = 8'h55;
        #1;
        check("mid_grant", bus8.req_ready, 1);
        step();
        bus8.req_valid = 2'b00;
        repeat (3) step();
        rst = 1'b1;
        bus8.req_valid = 2'b01;
        bus8.req_data0 = 8'hFF;
        #1;
        check("rst_gate", bus8.req_ready, 0);
        step();
        rst = 1'b0;
        last_served = 1'b1;
        bus8.req_valid = 2'b00;
        #1;
        check("mid_busy", bus8.busy, 0);
        check("mid_valid", bus8.res_valid, 0);
        for (int i = 0; i < W8 + 2; i++) begin
            step();
            check("no_stale", bus8.res_valid, 0);
        end
        run8(2'b01, 8'hFF, 8'h00, 0, 1'b0);

        // Randomized jobs.
        for (int i = 0; i < 16; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            run8(v, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        // W=1 build.
        run1(1'b1);
        run1(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
